uart_mmio_responder: RTL and testbench

Memory-mapped UART peripheral that answers the CPU's data-side load/store bus (rd, wr, addr, wdata, rdata) and raises an interrupt request. It sits beside the data RAM on the same bus. It decodes three word registers, serialises CPU-written bytes onto a TX line (8N1), and deserialises bytes from an RX line for the CPU to read.

---
 rtl/uart_mmio_responder_if.sv | 21 ++
 rtl/uart_mmio_responder.sv | 232 +++++++++++++++++++++++
 tb/tb_uart_mmio_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_mmio_responder_if.sv
// uart_mmio_responder_if
//   Data-side load/store bus shared by the CPU, the data RAM and the UART.
//   Handshake: there is no valid/ready pair. A write happens on every rising
//   clk edge where wr=1; a read is combinational while rd=1, and its side
//   effects (clearing rx_valid) happen on the rising edge where rd=1.
//   Signals:
//     rd    - read strobe (master -> slave)
//     wr    - write strobe (master -> slave)
//     addr  - byte address (master -> slave)
//     wdata - write data (master -> slave)
//     rdata - read data, 0 when not selected (slave -> master)
interface uart_mmio_responder_if;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output rd, output wr, output addr, output wdata, input rdata);
   modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_mmio_responder.sv
// uart_mmio_responder
//   Memory-mapped 8N1 UART. Three word registers at BASE_ADDR:
//     +0 TXD  (R/W) write starts a frame when TX is idle, read = last latched byte
//     +4 RXD  (R)   last received byte; a read clears rx_valid
//     +8 CON        {overrun, frame_err, tx_busy, rx_valid, tx_done, rx_irq_en, tx_irq_en}
//   Optional feature macro: UART_IRQ_EN. When undefined, irqout is constant 0
//   and CON bits 1:0 read 0 and ignore writes; status bits still work.
//   Ports:
//     clk          - system clock, rising edge
//     reset        - asynchronous active-high reset
//     bus          - slave side of the load/store bus
//     uart_rx      - serial input, asynchronous to clk
//     uart_tx      - serial output, registered, idles high
//     irqout       - level interrupt request, registered
//     tx_state_dbg - current TX FSM state (0 idle,1 start,2 data,3 stop)
//     rx_state_dbg - current RX FSM state (same encoding)
module uart_mmio_responder #(
   parameter int          CLKS_PER_BIT = 5208,
   parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_mmio_responder_if.slave bus,
   input  logic                 uart_rx,
   output logic                 uart_tx,
   output logic                 irqout,
   output logic [1:0]           tx_state_dbg,
   output logic [1:0]           rx_state_dbg
);

   localparam int             CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [29:0]    WA_TXD    = BASE_ADDR[31:2];
   localparam logic [29:0]    WA_RXD    = WA_TXD + 30'd1;
   localparam logic [29:0]    WA_CON    = WA_TXD + 30'd2;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} uart_state_e;

   uart_state_e   tx_state_q, tx_state_d, rx_state_q, rx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [2:0]    tx_idx_q, tx_idx_d, rx_idx_q, rx_idx_d;
   logic [7:0]    txd_q, txd_d, rxd_q, rxd_d, rx_shift_q, rx_shift_d;
   logic          uart_tx_q, uart_tx_d, tx_fin_q, tx_fin_d, tx_done_q, tx_done_d;
   logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
   logic          rx_valid_q, rx_valid_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
   logic          tx_irq_en_q, tx_irq_en_d, rx_irq_en_q, rx_irq_en_d, irq_q, irq_d;

   logic sel_txd, sel_rxd, sel_con, wr_txd, wr_con, rd_rxd, tx_busy;
   logic unused_bus_bits;

   assign sel_txd = (bus.addr[31:2] == WA_TXD);
   assign sel_rxd = (bus.addr[31:2] == WA_RXD);
   assign sel_con = (bus.addr[31:2] == WA_CON);
   assign wr_txd  = bus.wr & sel_txd;
   assign wr_con  = bus.wr & sel_con;
   assign rd_rxd  = bus.rd & sel_rxd;
   assign tx_busy = (tx_state_q != S_IDLE);
   assign unused_bus_bits = ^{bus.addr[1:0], bus.wdata};

   always_comb begin
      bus.rdata = 32'd0;
      if (bus.rd) begin
         if (sel_txd) bus.rdata = {24'd0, txd_q};
         else if (sel_rxd) bus.rdata = {24'd0, rxd_q};
         else if (sel_con) bus.rdata = {25'd0, overrun_q, frame_err_q, tx_busy, rx_valid_q,
                                        tx_done_q, rx_irq_en_q, tx_irq_en_q};
      end
   end

   always_comb begin
      tx_state_d  = tx_state_q;
      tx_cnt_d    = tx_cnt_q;
      tx_idx_d    = tx_idx_q;
      txd_d       = txd_q;
      tx_fin_d    = 1'b0;
      tx_done_d   = tx_done_q;
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_idx_d    = rx_idx_q;
      rx_shift_d  = rx_shift_q;
      rxd_d       = rxd_q;
      rx_valid_d  = rx_valid_q;
      frame_err_d = frame_err_q;
      overrun_d   = overrun_q;
      tx_irq_en_d = tx_irq_en_q;
      rx_irq_en_d = rx_irq_en_q;
      rx_s1_d     = uart_rx;
      rx_s2_d     = rx_s1_q;
      rx_prev_d   = rx_s2_q;

      // The line register follows the state one cycle later, so the start
      // bit appears the edge after the TXD write and every bit lasts a full
      // CLKS_PER_BIT from that point.
      case (tx_state_q)
         S_START: uart_tx_d = 1'b0;
         S_DATA:  uart_tx_d = txd_q[tx_idx_q];
         default: uart_tx_d = 1'b1;
      endcase

      case (tx_state_q)
         S_IDLE: if (wr_txd) begin
            txd_d      = bus.wdata[7:0];
            tx_state_d = S_START;
            tx_cnt_d   = '0;
         end
         S_START: if (tx_cnt_q == BIT_LAST) begin
            tx_state_d = S_DATA;
            tx_cnt_d   = '0;
            tx_idx_d   = 3'd0;
         end else tx_cnt_d = tx_cnt_q + 1'b1;
         S_DATA: if (tx_cnt_q == BIT_LAST) begin
            tx_cnt_d = '0;
            if (tx_idx_q == 3'd7) tx_state_d = S_STOP;
            else tx_idx_d = tx_idx_q + 3'd1;
         end else tx_cnt_d = tx_cnt_q + 1'b1;
         default: if (tx_cnt_q == BIT_LAST) begin
            tx_state_d = S_IDLE;
            tx_cnt_d   = '0;
            tx_idx_d   = 3'd0;
            tx_fin_d   = 1'b1;
         end else tx_cnt_d = tx_cnt_q + 1'b1;
      endcase

      // Software clears come first so that a hardware event on the same
      // edge always survives.
      if (wr_con) begin
`ifdef UART_IRQ_EN
         tx_irq_en_d = bus.wdata[0];
         rx_irq_en_d = bus.wdata[1];
`endif
         if (bus.wdata[2]) tx_done_d   = 1'b0;
         if (bus.wdata[5]) frame_err_d = 1'b0;
         if (bus.wdata[6]) overrun_d   = 1'b0;
      end
      if (rd_rxd) rx_valid_d = 1'b0;
      // tx_fin_q delays the done flag by one edge so it lines up with the
      // end of the stop bit on the (lagging) line register.
      if (tx_fin_q) tx_done_d = 1'b1;

      case (rx_state_q)
         S_IDLE: if (rx_prev_q && !rx_s2_q) begin
            rx_state_d = S_START;
            rx_cnt_d   = '0;
         end
         S_START: if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_d = '0;
            rx_idx_d = 3'd0;
            rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
         end else rx_cnt_d = rx_cnt_q + 1'b1;
         S_DATA: if (rx_cnt_q == BIT_LAST) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
            else rx_idx_d = rx_idx_q + 3'd1;
         end else rx_cnt_d = rx_cnt_q + 1'b1;
         default: if (rx_cnt_q == BIT_LAST) begin
            rx_state_d = S_IDLE;
            rx_cnt_d   = '0;
            rx_idx_d   = 3'd0;
            if (rx_s2_q) begin
               rxd_d      = rx_shift_q;
               rx_valid_d = 1'b1;
               if (rx_valid_q) overrun_d = 1'b1;
            end else begin
               frame_err_d = 1'b1;
            end
         end else rx_cnt_d = rx_cnt_q + 1'b1;
      endcase

`ifdef UART_IRQ_EN
      irq_d = (tx_irq_en_d & tx_done_d) | (rx_irq_en_d & rx_valid_d);
`else
      irq_d = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_idx_q    <= 3'd0;
         txd_q       <= 8'd0;
         uart_tx_q   <= 1'b1;
         tx_fin_q    <= 1'b0;
         tx_done_q   <= 1'b0;
         rx_state_q  <= S_IDLE;
         rx_cnt_q    <= '0;
         rx_idx_q    <= 3'd0;
         rx_shift_q  <= 8'd0;
         rxd_q       <= 8'd0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         tx_irq_en_q <= 1'b0;
         rx_irq_en_q <= 1'b0;
         irq_q       <= 1'b0;
         // Synchroniser resets to the idle line level so no false edge is seen.
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_idx_q    <= tx_idx_d;
         txd_q       <= txd_d;
         uart_tx_q   <= uart_tx_d;
         tx_fin_q    <= tx_fin_d;
         tx_done_q   <= tx_done_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_idx_q    <= rx_idx_d;
         rx_shift_q  <= rx_shift_d;
         rxd_q       <= rxd_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
         tx_irq_en_q <= tx_irq_en_d;
         rx_irq_en_q <= rx_irq_en_d;
         irq_q       <= irq_d;
         rx_s1_q     <= rx_s1_d;
         rx_s2_q     <= rx_s2_d;
         rx_prev_q   <= rx_prev_d;
      end
   end

   assign uart_tx      = uart_tx_q;
   assign irqout       = irq_q;
   assign tx_state_dbg = tx_state_q;
   assign rx_state_dbg = rx_state_q;

endmodule

// File: tb/tb_uart_mmio_responder.sv
// tb_uart_mmio_responder
//   Bench for uart_mmio_responder with CLKS_PER_BIT=4. Register-access vector
//   table, hand-written frame sequences and randomized TX/RX frames checked
//   against a register-level model of the UART.
module tb_uart_mmio_responder;
   localparam int          C     = 4;
   localparam logic [31:0] BASE  = 32'h40000018;
   localparam logic [31:0] A_TXD = BASE;
   localparam logic [31:0] A_RXD = BASE + 32'd4;
   localparam logic [31:0] A_CON = BASE + 32'd8;
`ifdef UART_IRQ_EN
   localparam logic [1:0]  EN_MASK = 2'b11;
`else
   localparam logic [1:0]  EN_MASK = 2'b00;
`endif

   localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_NORD = 2'd2;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       uart_rx = 1'b1;
   logic       uart_tx, irqout;
   logic [1:0] tx_dbg, rx_dbg;

   uart_mmio_responder_if bus_if();

   uart_mmio_responder #(.CLKS_PER_BIT(C), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .bus(bus_if), .uart_rx(uart_rx), .uart_tx(uart_tx),
      .irqout(irqout), .tx_state_dbg(tx_dbg), .rx_state_dbg(rx_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   int total = 0;
   int bad   = 0;

   // register-level model
   logic [7:0] m_rxd;
   logic       m_valid, m_ferr, m_ovr, m_txdone;
   logic [1:0] m_en;

   task automatic model_reset();
      m_rxd = 8'd0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; m_txdone = 1'b0; m_en = 2'b00;
   endtask

   function automatic logic [31:0] exp_con(input logic busy);
      return {25'd0, m_ovr, m_ferr, busy, m_valid, m_txdone, m_en & EN_MASK};
   endfunction

   function automatic logic exp_irq();
`ifdef UART_IRQ_EN
      return (m_en[0] & m_txdone) | (m_en[1] & m_valid);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input int j);
      if (j == 0) return 1'b0;
      if (j == 9) return 1'b1;
      return b[j-1];
   endfunction

   // scoreboard
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // driver tasks
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      bus_if.wr = 1'b1; bus_if.addr = a; bus_if.wdata = d;
      @(negedge clk);
      bus_if.wr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
      @(negedge clk);
      bus_if.rd = 1'b1; bus_if.addr = a;
      #1 d = bus_if.rdata;
      @(negedge clk);
      bus_if.rd = 1'b0;
   endtask

   task automatic read_check(input logic [31:0] a, input logic [31:0] exp, input string name);
      logic [31:0] r;
      bus_read(a, r);
      check(name, r, exp);
   endtask

   task automatic read_rxd_check(input string name);
      read_check(A_RXD, {24'd0, m_rxd}, name);
      m_valid = 1'b0;
   endtask

   task automatic con_write(input logic [31:0] w);
      bus_write(A_CON, w);
      m_en = w[1:0];
      if (w[2]) m_txdone = 1'b0;
      if (w[5]) m_ferr = 1'b0;
      if (w[6]) m_ovr = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      @(negedge clk);
      for (int j = 0; j < 10; j++) begin
         uart_rx = (j == 9) ? stop : frame_bit(b, j);
         repeat (C) @(negedge clk);
      end
      uart_rx = 1'b1;
      repeat (3) @(negedge clk);
      if (stop) begin
         if (m_valid) m_ovr = 1'b1;
         m_rxd = b;
         m_valid = 1'b1;
      end else begin
         m_ferr = 1'b1;
      end
   endtask

   // Writes TXD and checks every cycle of the frame; optionally a second
   // TXD write is issued two cycles after the first (it must be dropped).
   task automatic check_tx_frame(input logic [7:0] b, input logic inject, input logic [7:0] inj_b);
      bus_write(A_TXD, {24'd0, b});
      for (int i = 0; i < 10 * C; i++) begin
         @(negedge clk);
         if (inject && i == 1) bus_if.wr = 1'b0;
         check("tx_line", 32'(uart_tx), 32'(frame_bit(b, i / C)));
         if (inject && i == 0) begin
            bus_if.wr = 1'b1; bus_if.addr = A_TXD; bus_if.wdata = {24'd0, inj_b};
         end
         if (i == 20) begin
            bus_if.rd = 1'b1; bus_if.addr = A_CON;
            #1 check("con_busy", bus_if.rdata, exp_con(1'b1));
            bus_if.rd = 1'b0;
         end
      end
      m_txdone = 1'b1;
      read_check(A_CON, exp_con(1'b0), "con_after_tx");
      check("irq_after_tx", 32'(irqout), 32'(exp_irq()));
   endtask

   vec_t vecs[14];

   initial begin
      logic [7:0] rb;
      logic       rs;
      bus_if.rd = 1'b0; bus_if.wr = 1'b0; bus_if.addr = 32'd0; bus_if.wdata = 32'd0;
      model_reset();

      // reset state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_tx", 32'(uart_tx), 32'd1);
      check("reset_irq", 32'(irqout), 32'd0);
      check("reset_txst", 32'(tx_dbg), 32'd0);
      check("reset_rxst", 32'(rx_dbg), 32'd0);
      reset = 1'b0;
      read_check(A_CON, 32'd0, "reset_con");
      read_check(A_TXD, 32'd0, "reset_txd");
      read_check(A_RXD, 32'd0, "reset_rxd");

      // register access table
      vecs[0]  = '{OP_RD,   A_CON,          32'd0,   32'd0};
      vecs[1]  = '{OP_NORD, A_CON,          32'd0,   32'd0};
      vecs[2]  = '{OP_WR,   A_CON,          32'h7F,  32'd0};
      vecs[3]  = '{OP_RD,   A_CON,          32'd0,   {30'd0, EN_MASK}};
      vecs[4]  = '{OP_NORD, A_CON,          32'd0,   32'd0};
      vecs[5]  = '{OP_RD,   A_CON + 32'd3,  32'd0,   {30'd0, EN_MASK}};
      vecs[6]  = '{OP_RD,   BASE + 32'd12,  32'd0,   32'd0};
      vecs[7]  = '{OP_RD,   BASE - 32'd4,   32'd0,   32'd0};
      vecs[8]  = '{OP_WR,   BASE + 32'd12,  32'hFF,  32'd0};
      vecs[9]  = '{OP_RD,   A_CON,          32'd0,   {30'd0, EN_MASK}};
      vecs[10] = '{OP_WR,   A_CON,          32'h01,  32'd0};
      vecs[11] = '{OP_RD,   A_CON,          32'd0,   {30'd0, EN_MASK & 2'b01}};
      vecs[12] = '{OP_WR,   A_CON,          32'h00,  32'd0};
      vecs[13] = '{OP_RD,   A_CON,          32'd0,   32'd0};
      for (int v = 0; v < 14; v++) begin
         case (vecs[v].op)
            OP_WR: bus_write(vecs[v].addr, vecs[v].wdata);
            OP_RD: read_check(vecs[v].addr, vecs[v].exp, $sformatf("vec%0d", v));
            default: begin
               @(negedge clk);
               bus_if.rd = 1'b0; bus_if.addr = vecs[v].addr;
               #1 check($sformatf("vec%0d_nord", v), bus_if.rdata, vecs[v].exp);
            end
         endcase
      end

      // transmit 0xA5, then clear tx_done
      check_tx_frame(8'hA5, 1'b0, 8'h00);
      con_write(32'h04);
      read_check(A_CON, exp_con(1'b0), "con_done_clr");

      // busy drop
      check_tx_frame(8'h11, 1'b1, 8'h22);
      read_check(A_TXD, 32'h11, "txd_busy_drop");
      con_write(32'h04);

      // random transmit with random irq enables
      for (int n = 0; n < 3; n++) begin
         con_write(32'($urandom_range(0, 3)) | 32'h04);
         check_tx_frame(8'($urandom_range(0, 255)), 1'b0, 8'h00);
      end
      con_write(32'h04);

      // receive plus rx irq
      con_write(32'h02);
      send_rx(8'h3C, 1'b1);
      check("rx_irq_set", 32'(irqout), 32'(exp_irq()));
      read_check(A_CON, exp_con(1'b0), "rx_con_valid");
      read_rxd_check("rxd_3c");
      check("rx_irq_clr", 32'(irqout), 32'(exp_irq()));

      // one-cycle glitch
      @(negedge clk) uart_rx = 1'b0;
      @(negedge clk) uart_rx = 1'b1;
      repeat (8) @(negedge clk);
      check("glitch_rxst", 32'(rx_dbg), 32'd0);
      read_check(A_CON, exp_con(1'b0), "glitch_con");
      read_rxd_check("glitch_rxd");

      // framing error
      send_rx(8'h55, 1'b0);
      read_check(A_CON, exp_con(1'b0), "ferr_con");
      read_rxd_check("ferr_rxd");
      con_write(32'h60);
      read_check(A_CON, exp_con(1'b0), "ferr_clr");

      // overrun
      send_rx(8'hA1, 1'b1);
      send_rx(8'h7E, 1'b1);
      read_check(A_CON, exp_con(1'b0), "ovr_con");
      read_rxd_check("ovr_rxd");
      con_write(32'h40);

      // random receive against the model
      for (int n = 0; n < 10; n++) begin
         rb = 8'($urandom_range(0, 255));
         rs = ($urandom_range(0, 3) != 0);
         send_rx(rb, rs);
         check("rnd_irq", 32'(irqout), 32'(exp_irq()));
         read_check(A_CON, exp_con(1'b0), "rnd_con");
         case ($urandom_range(0, 2))
            0: read_rxd_check("rnd_rxd");
            1: con_write(32'($urandom_range(0, 3)) | 32'h60);
            default: ;
         endcase
      end

      // reset in the middle of a TX and an RX frame
      bus_write(A_TXD, 32'h00);
      @(negedge clk) uart_rx = 1'b0;
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1 check("async_reset_tx", 32'(uart_tx), 32'd1);
      check("async_reset_txst", 32'(tx_dbg), 32'd0);
      uart_rx = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
      read_check(A_CON, 32'd0, "midreset_con");
      read_check(A_RXD, 32'd0, "midreset_rxd");
      check("midreset_rxst", 32'(rx_dbg), 32'd0);
      check("midreset_irq", 32'(irqout), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
